// File: rtl/user_stream_arbiter.sv
// user_stream_arbiter: round-robin, packet-locked arbiter that merges N_CH user streams into one.
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   cntrl_ch_en_i       per-port enable; a disabled port is never newly granted
//   in_tid_i/tdata/tkeep/tvld/tlast  per-port stream inputs (port k in slice k)
//   in_trdy_o           per-port ready; only the granted port can see a 1
//   out_tid/tdata/tkeep/tvld/tlast_o registered merged stream, out_rdy_i its ready
//   grant_o             one-hot grant held for a whole packet, zero when idle
//   busy_o              high while a packet is in progress
module user_stream_arbiter #(
    parameter int N_CH     = 4,
    parameter int ID_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_CH-1:0]          cntrl_ch_en_i,
    input  logic [N_CH*ID_WIDTH-1:0] in_tid_i,
    input  logic [N_CH*32-1:0]       in_tdata_i,
    input  logic [N_CH*4-1:0]        in_tkeep_i,
    input  logic [N_CH-1:0]          in_tvld_i,
    input  logic [N_CH-1:0]          in_tlast_i,
    output logic [N_CH-1:0]          in_trdy_o,
    output logic [ID_WIDTH-1:0]      out_tid_o,
    output logic [31:0]              out_tdata_o,
    output logic [3:0]               out_tkeep_o,
    output logic                     out_tvld_o,
    output logic                     out_tlast_o,
    input  logic                     out_rdy_i,
    output logic [N_CH-1:0]          grant_o,
    output logic                     busy_o
);
    localparam int GW = $clog2(N_CH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       last_grant, pick;
    logic                found;
    logic [N_CH-1:0]     cand;
    logic                pipe_rdy, accept, pkt_end;
    logic [ID_WIDTH-1:0] sel_tid;
    logic [31:0]         sel_tdata;
    logic [3:0]          sel_tkeep;
    logic                sel_tvld, sel_tlast;

    assign cand      = in_tvld_i & cntrl_ch_en_i;
    assign busy_o    = state == BUSY;
    assign pipe_rdy  = ~out_tvld_o | out_rdy_i;
    assign in_trdy_o = grant_o & {N_CH{pipe_rdy & busy_o}};
    assign accept    = busy_o & pipe_rdy & sel_tvld;
    assign pkt_end   = accept & sel_tlast;

    // Circular search starting just after last_grant: ports above it first, then wrap to port 0.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        for (int j = 0; j < N_CH; j++)
            if (!found && cand[j] && j > int'(last_grant)) begin
                pick  = GW'(j);
                found = 1'b1;
            end
        for (int j = 0; j < N_CH; j++)
            if (!found && cand[j]) begin
                pick  = GW'(j);
                found = 1'b1;
            end
    end

    // last_grant also names the port currently holding the grant while BUSY.
    always_comb begin
        sel_tid   = '0;
        sel_tdata = '0;
        sel_tkeep = '0;
        sel_tvld  = 1'b0;
        sel_tlast = 1'b0;
        for (int j = 0; j < N_CH; j++)
            if (last_grant == GW'(j)) begin
                sel_tid   = in_tid_i[j*ID_WIDTH +: ID_WIDTH];
                sel_tdata = in_tdata_i[j*32 +: 32];
                sel_tkeep = in_tkeep_i[j*4 +: 4];
                sel_tvld  = in_tvld_i[j];
                sel_tlast = in_tlast_i[j];
            end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = |cand ? BUSY : IDLE;
        else               state_nxt = pkt_end ? IDLE : BUSY;
    end

    // Reset value N_CH-1 makes port 0 the first in line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_o    <= '0;
            last_grant <= GW'(N_CH - 1);
        end else if (state == IDLE && |cand) begin
            grant_o    <= N_CH'(1) << pick;
            last_grant <= pick;
        end else if (pkt_end) begin
            grant_o    <= '0;
        end
    end

    // Single output stage; it only moves when empty or drained so data stays stable under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_tvld_o  <= 1'b0;
            out_tid_o   <= '0;
            out_tdata_o <= '0;
            out_tkeep_o <= '0;
            out_tlast_o <= 1'b0;
        end else if (pipe_rdy) begin
            out_tvld_o <= accept;
            if (accept) begin
                out_tid_o   <= sel_tid;
                out_tdata_o <= sel_tdata;
                out_tkeep_o <= sel_tkeep;
                out_tlast_o <= sel_tlast;
            end
        end
    end
endmodule

// File: tb/tb_user_stream_arbiter.sv
// tb_user_stream_arbiter: directed checks of grant order, packet lock, backpressure and reset.
module tb_user_stream_arbiter;
    localparam int N = 4;
    localparam int W = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] en, vld, last, trdy, grant;
    logic [N*W-1:0] tid;
    logic [N*32-1:0] data;
    logic [N*4-1:0] keep;
    logic out_rdy, out_tvld, out_tlast, busy;
    logic [W-1:0] out_tid;
    logic [31:0] out_tdata;
    logic [3:0] out_tkeep;

    int len[N], npkt[N], beat[N], dptr[N];
    logic [31:0] base[N];
    logic [W-1:0] tidv[N];
    logic [N-1:0] acc, gprev;
    logic [31:0] dlog[$], glog[$], dexp[$], gexp[$];
    int gcyc[$];
    int cyc = 0;
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    user_stream_arbiter #(.N_CH(N), .ID_WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .cntrl_ch_en_i(en),
        .in_tid_i(tid), .in_tdata_i(data), .in_tkeep_i(keep),
        .in_tvld_i(vld), .in_tlast_i(last), .in_trdy_o(trdy),
        .out_tid_o(out_tid), .out_tdata_o(out_tdata), .out_tkeep_o(out_tkeep),
        .out_tvld_o(out_tvld), .out_tlast_o(out_tlast), .out_rdy_i(out_rdy),
        .grant_o(grant), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            vld[k] = npkt[k] > 0;
            last[k] = beat[k] == len[k] - 1;
            data[k*32 +: 32] = base[k] + 32'(dptr[k]);
            keep[k*4 +: 4] = 4'(dptr[k] + 1);
            tid[k*W +: W] = tidv[k];
        end
    endtask

    // One clock: present inputs, note handshakes, cross the edge, advance the requesters.
    task automatic tick();
        drive();
        #1;
        acc = vld & trdy;
        if (out_tvld && out_rdy) dlog.push_back(out_tdata);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int k = 0; k < N; k++)
            if (acc[k]) begin
                dptr[k]++;
                beat[k]++;
                if (beat[k] == len[k]) begin
                    beat[k] = 0;
                    npkt[k]--;
                end
            end
        if (grant != 0 && gprev == 0) begin
            glog.push_back(32'(grant));
            gcyc.push_back(cyc);
        end
        gprev = grant;
    endtask

    task automatic clear_logs();
        dlog.delete();
        glog.delete();
        gcyc.delete();
        cyc = 0;
    endtask

    task automatic cmp_logs(input string tag);
        check({tag, "_nbeats"}, 32'(dlog.size()), 32'(dexp.size()));
        for (int i = 0; i < dexp.size(); i++)
            check({tag, "_beat"}, i < dlog.size() ? dlog[i] : 32'hDEAD_BEEF, dexp[i]);
        check({tag, "_ngrants"}, 32'(glog.size()), 32'(gexp.size()));
        for (int i = 0; i < gexp.size(); i++)
            check({tag, "_grant"}, i < glog.size() ? glog[i] : 32'hDEAD_BEEF, gexp[i]);
    endtask

    initial begin
        en = '1;
        out_rdy = 1'b1;
        gprev = '0;
        for (int k = 0; k < N; k++) begin
            len[k] = 1; npkt[k] = 0; beat[k] = 0; dptr[k] = 0;
            base[k] = '0; tidv[k] = W'(k + 1);
        end
        drive();
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_tvld", 32'(out_tvld), 32'h0);
        check("rst_trdy", 32'(trdy), 32'h0);
        check("rst_out", {out_tdata[15:0], out_tid[7:0], out_tkeep, 3'b0, out_tlast}, 32'h0);

        // Single port 2, tid 5, three beats.
        reset_n = 1'b1;
        tidv[2] = 5; base[2] = 32'hA1; len[2] = 3; npkt[2] = 1;
        tick();
        check("t1_grant", 32'(grant), 32'h4);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_trdy", 32'(trdy), 32'h4);
        check("t1_tvld_c1", 32'(out_tvld), 32'h0);
        tick();
        check("t1_tvld_c2", 32'(out_tvld), 32'h1);
        check("t1_d0", out_tdata, 32'hA1);
        check("t1_tid", 32'(out_tid), 32'h5);
        check("t1_keep0", 32'(out_tkeep), 32'h1);
        check("t1_last0", 32'(out_tlast), 32'h0);
        tick();
        check("t1_d1", out_tdata, 32'hA2);
        tick();
        check("t1_d2", out_tdata, 32'hA3);
        check("t1_last2", 32'(out_tlast), 32'h1);
        check("t1_keep2", 32'(out_tkeep), 32'h3);
        check("t1_busy_c4", 32'(busy), 32'h0);
        check("t1_grant_c4", 32'(grant), 32'h0);
        tick();
        check("t1_tvld_c5", 32'(out_tvld), 32'h0);

        // All four ports, 2-beat packets, port 0 twice; fresh reset so port 0 leads.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            len[k] = 2; beat[k] = 0; dptr[k] = 0;
            base[k] = 32'h100 * (k + 1); npkt[k] = k == 0 ? 2 : 1;
        end
        clear_logs();
        repeat (18) tick();
        dexp = '{32'h100, 32'h101, 32'h200, 32'h201, 32'h300, 32'h301, 32'h400, 32'h401, 32'h102, 32'h103};
        gexp = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
        cmp_logs("t2");
        for (int i = 0; i < 5; i++)
            check("t2_gcyc", i < gcyc.size() ? 32'(gcyc[i]) : 32'hDEAD_BEEF, 32'(1 + 3 * i));

        // Backpressure: out_rdy low five cycles with beat 0 of 4 on the output.
        len[0] = 4; base[0] = 32'h5500_0000; dptr[0] = 0; beat[0] = 0; npkt[0] = 1;
        clear_logs();
        tick();
        tick();
        out_rdy = 1'b0;
        repeat (5) begin
            tick();
            check("t3_hold_tvld", 32'(out_tvld), 32'h1);
            check("t3_hold_data", out_tdata, 32'h5500_0000);
            check("t3_hold_trdy", 32'(trdy), 32'h0);
        end
        out_rdy = 1'b1;
        repeat (8) tick();
        dexp = '{32'h5500_0000, 32'h5500_0001, 32'h5500_0002, 32'h5500_0003};
        gexp = '{32'h1};
        cmp_logs("t3");

        // Port 1 loses its enable after beat 1 of 4; port 2 waits behind it.
        len[1] = 4; base[1] = 32'h1000; dptr[1] = 0; beat[1] = 0; npkt[1] = 2;
        len[2] = 1; base[2] = 32'h2000; dptr[2] = 0; beat[2] = 0; npkt[2] = 1;
        clear_logs();
        tick();
        check("t4_grant", 32'(grant), 32'h2);
        tick();
        en[1] = 1'b0;
        tick();
        check("t4_lock", 32'(grant), 32'h2);
        repeat (12) tick();
        dexp = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h2000};
        gexp = '{32'h2, 32'h4};
        cmp_logs("t4");
        check("t4_idle_grant", 32'(grant), 32'h0);
        check("t4_idle_trdy", 32'(trdy), 32'h0);
        check("t4_idle_busy", 32'(busy), 32'h0);

        // Reset during port 3's packet, then port 0 and port 3 contend.
        en = '1;
        npkt[1] = 0;
        len[3] = 4; base[3] = 32'h3000; dptr[3] = 0; beat[3] = 0; npkt[3] = 1;
        clear_logs();
        tick();
        check("t5_grant", 32'(grant), 32'h8);
        tick();
        tick();
        check("t5_pre_tvld", 32'(out_tvld), 32'h1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_tvld", 32'(out_tvld), 32'h0);
        check("t5_rst_grant", 32'(grant), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_trdy", 32'(trdy), 32'h0);
        dptr[3] = 0; beat[3] = 0; npkt[3] = 1;
        len[0] = 1; base[0] = 32'h4000; dptr[0] = 0; beat[0] = 0; npkt[0] = 1;
        tick();
        tick();
        check("t5_in_rst_grant", 32'(grant), 32'h0);
        reset_n = 1'b1;
        clear_logs();
        tick();
        check("t5_first", 32'(grant), 32'h1);
        repeat (10) tick();
        dexp = '{32'h4000, 32'h3000, 32'h3001, 32'h3002, 32'h3003};
        gexp = '{32'h1, 32'h8};
        cmp_logs("t5");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
